// File: rtl/step_counter.sv
// Registered up/down counter over 0..LIMIT with a programmable step, synchronous
// clear/load, and a wrap/saturate overflow mode.
module step_counter #(
    parameter int N        = 4,
    parameter int LIMIT    = 2**N - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] din,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] step,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         at_max,
    output logic         at_zero
);

    localparam logic [N:0]   LIM_X = (N+1)'(LIMIT);
    localparam logic [N:0]   MOD_X = (N+1)'(LIMIT + 1);
    localparam logic [N-1:0] LIM_N = N'(LIMIT);

    logic [N-1:0] count_r;
    logic         wrap_r;
    logic [N-1:0] step_s;
    logic [N:0]   sum_s;
    logic [N-1:0] next_s;
    logic         ovf_s;

    // Next count and overflow flag for an enabled step; sums kept N+1 bits wide.
    always_comb begin
        step_s = ({1'b0, step} > LIM_X) ? LIM_N : step;
        sum_s  = {1'b0, count_r} + {1'b0, step_s};
        next_s = count_r;
        ovf_s  = 1'b0;
        if (up) begin
            if (sum_s > LIM_X) begin
                ovf_s = 1'b1;
                if (SATURATE) begin
                    next_s = LIM_N;
                end else begin
                    next_s = N'(sum_s - MOD_X);
                end
            end else begin
                next_s = sum_s[N-1:0];
            end
        end else begin
            if (step_s <= count_r) begin
                next_s = count_r - step_s;
            end else begin
                ovf_s = 1'b1;
                if (SATURATE) begin
                    next_s = {N{1'b0}};
                end else begin
                    next_s = N'({1'b0, count_r} + MOD_X - {1'b0, step_s});
                end
            end
        end
    end

    // Count and wrap-pulse registers: clr > load > en > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {N{1'b0}};
            wrap_r  <= 1'b0;
        end else if (clr) begin
            count_r <= {N{1'b0}};
            wrap_r  <= 1'b0;
        end else if (load) begin
            count_r <= ({1'b0, din} > LIM_X) ? LIM_N : din;
            wrap_r  <= 1'b0;
        end else if (en) begin
            count_r <= next_s;
            wrap_r  <= ovf_s;
        end else begin
            count_r <= count_r;
            wrap_r  <= 1'b0;
        end
    end

    assign count   = count_r;
    assign wrap    = wrap_r;
    assign at_max  = (count_r == LIM_N);
    assign at_zero = (count_r == {N{1'b0}});

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench driving three step_counter configurations with shared stimulus
// and comparing each against an integer modulo/clamp model.
module tb_step_counter;

    logic       clk = 1'b0;
    logic       rst_n, clr, load, en, up;
    logic [3:0] din, step;

    logic [3:0] cnt0, cnt1, cnt2;
    logic       wr0, wr1, wr2, mx0, mx1, mx2, zr0, zr1, zr2;

    int checks = 0;
    int errors = 0;

    int lim [3] = '{15, 9, 9};
    int sat [3] = '{0, 0, 1};
    int mc  [3] = '{0, 0, 0};
    int mw  [3] = '{0, 0, 0};

    typedef struct packed {
        logic [3:0] c;
        logic       w;
        logic       m;
        logic       z;
    } exp_t;

    exp_t sbq [$];

    always #5 clk = ~clk;

    step_counter #(.N(4), .LIMIT(15), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .din(din), .en(en),
        .up(up), .step(step), .count(cnt0), .wrap(wr0), .at_max(mx0), .at_zero(zr0));
    step_counter #(.N(4), .LIMIT(9), .SATURATE(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .din(din), .en(en),
        .up(up), .step(step), .count(cnt1), .wrap(wr1), .at_max(mx1), .at_zero(zr1));
    step_counter #(.N(4), .LIMIT(9), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .din(din), .en(en),
        .up(up), .step(step), .count(cnt2), .wrap(wr2), .at_max(mx2), .at_zero(zr2));

    task automatic chk(input string tag, input int inst, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s u%0d observed %0h expected %0h", tag, inst, obs, exp);
        end
    endtask

    // Reference behaviour expressed as modulo arithmetic on plain integers.
    task automatic model(input int i, input logic c_i, l_i, e_i, u_i, input logic [3:0] d_i, s_i);
        int s;
        int t;
        if (c_i) begin
            mc[i] = 0; mw[i] = 0;
        end else if (l_i) begin
            mc[i] = (int'(d_i) > lim[i]) ? lim[i] : int'(d_i);
            mw[i] = 0;
        end else if (e_i) begin
            s = (int'(s_i) > lim[i]) ? lim[i] : int'(s_i);
            t = u_i ? mc[i] + s : mc[i] - s;
            mw[i] = (t > lim[i] || t < 0) ? 1 : 0;
            if (mw[i] == 0)      mc[i] = t;
            else if (sat[i] == 1) mc[i] = u_i ? lim[i] : 0;
            else                 mc[i] = (t + lim[i] + 1) % (lim[i] + 1);
        end else begin
            mw[i] = 0;
        end
    endtask

    task automatic check_inst(input string tag, input int i, input exp_t e);
        logic [3:0] c;
        logic w, m, z;
        case (i)
            0:       begin c = cnt0; w = wr0; m = mx0; z = zr0; end
            1:       begin c = cnt1; w = wr1; m = mx1; z = zr1; end
            default: begin c = cnt2; w = wr2; m = mx2; z = zr2; end
        endcase
        chk({tag, ".count"},   i, c, e.c);
        chk({tag, ".wrap"},    i, {3'b000, w}, {3'b000, e.w});
        chk({tag, ".at_max"},  i, {3'b000, m}, {3'b000, e.m});
        chk({tag, ".at_zero"}, i, {3'b000, z}, {3'b000, e.z});
    endtask

    task automatic cyc(input string tag, input logic c_i, l_i, e_i, u_i, input logic [3:0] d_i, s_i);
        exp_t e;
        clr = c_i; load = l_i; en = e_i; up = u_i; din = d_i; step = s_i;
        for (int i = 0; i < 3; i++) begin
            model(i, c_i, l_i, e_i, u_i, d_i, s_i);
            e.c = 4'(mc[i]);
            e.w = (mw[i] != 0);
            e.m = (mc[i] == lim[i]);
            e.z = (mc[i] == 0);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e = sbq.pop_front();
            check_inst(tag, i, e);
        end
    endtask

    task automatic check_reset_all(input string tag);
        chk({tag, ".count"}, 0, cnt0, 4'h0);
        chk({tag, ".count"}, 1, cnt1, 4'h0);
        chk({tag, ".count"}, 2, cnt2, 4'h0);
        chk({tag, ".wrap"}, 0, {3'b000, wr0}, 4'h0);
        chk({tag, ".wrap"}, 1, {3'b000, wr1}, 4'h0);
        chk({tag, ".wrap"}, 2, {3'b000, wr2}, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0;
        din = 4'h0; step = 4'h0;
        #2;
        check_reset_all("reset");
        chk("reset.at_zero", 0, {3'b000, zr0}, 4'h1);
        chk("reset.at_max",  0, {3'b000, mx0}, 4'h0);
        chk("reset.at_max",  1, {3'b000, mx1}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full wrap of the default configuration; directed spot checks too.
        for (int k = 0; k < 16; k++) begin
            cyc("count16", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h1);
            if (k == 14) chk("count16.at15", 0, {3'b000, mx0}, 4'h1);
        end
        chk("count16.final", 0, cnt0, 4'h0);
        chk("count16.wrap", 0, {3'b000, wr0}, 4'h1);

        // Modulo-10 arithmetic.
        cyc("ld7",   1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 4'h0);
        cyc("up4",   1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h4);
        chk("up4.mod10", 1, cnt1, 4'h1);
        cyc("dn3",   1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h3);
        chk("dn3.mod10", 1, cnt1, 4'h8);
        cyc("dn8",   1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h8);
        chk("dn8.mod10", 1, cnt1, 4'h0);

        // Saturation.
        cyc("ld8",   1'b0, 1'b1, 1'b0, 1'b0, 4'h8, 4'h0);
        cyc("sup5a", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h5);
        cyc("sup5b", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h5);
        chk("sup5b.sat", 2, cnt2, 4'h9);
        chk("sup5b.wrap", 2, {3'b000, wr2}, 4'h1);
        cyc("sdn15", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'hf);
        cyc("sdn1",  1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1);
        chk("sdn1.sat", 2, cnt2, 4'h0);

        // Priority.
        cyc("ld5",     1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 4'h0);
        cyc("all3",    1'b1, 1'b1, 1'b1, 1'b1, 4'hc, 4'h1);
        cyc("ld_en",   1'b0, 1'b1, 1'b1, 1'b1, 4'hc, 4'h1);
        chk("ld_en.val", 0, cnt0, 4'hc);
        cyc("ld15",    1'b0, 1'b1, 1'b0, 1'b0, 4'hf, 4'h0);
        chk("ld15.clamp", 1, cnt1, 4'h9);

        // Hold cases.
        cyc("step0",   1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'h0);
        cyc("en0",     1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h3);

        // Mixed random traffic.
        for (int k = 0; k < 40; k++) begin
            cyc("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-count.
        cyc("pre_clr", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int k = 0; k < 6; k++) cyc("to6", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h1);
        chk("to6.val", 0, cnt0, 4'h6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_all("async");
        for (int i = 0; i < 3; i++) begin mc[i] = 0; mw[i] = 0; end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_reset_all("held");
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h1);
        chk("post_rst.val", 0, cnt0, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_counter.md
Name: step_counter

Overview:
- Parametrised sequential successor to the combinational +1 incrementor in the arithmetic library.
- Registered up/down counter with a programmable step, a programmable terminal value LIMIT, and a selectable overflow mode: wrap or saturate.
- Provides synchronous load and clear, plus status flags.
- Intended as the shared counting primitive for timers, address generators and decade/BCD stages.

Parameters:
- N, 4, counter/step/data width in bits (N >= 2).
- LIMIT, 2**N-1, largest legal count value; range is 0..LIMIT; 1 <= LIMIT <= 2**N-1.
- SATURATE, 0, overflow mode: 0 = modulo-(LIMIT+1) wrap, 1 = clamp at 0 / LIMIT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of din.
- din  input  N  load value.
- en  input  1  count enable.
- up  input  1  direction: 1 = add step, 0 = subtract step.
- step  input  N  increment magnitude per enabled cycle.
- count  output  N  registered count value.
- wrap  output  1  registered one-cycle pulse: the last update overflowed or underflowed (wrapped or saturated).
- at_max  output  1  combinational: count == LIMIT.
- at_zero  output  1  combinational: count == 0.

Behaviour:
Reset:
- rst_n low -> count = 0 and wrap = 0 immediately, independent of clk.
- Hence at_zero = 1 and at_max = 0 (LIMIT >= 1).
- Deassertion is honoured on the next rising edge.

Priority per rising edge is clr > load > en > hold:
- clr = 1: count <= 0; wrap <= 0.
- load = 1: count <= min(din, LIMIT); wrap <= 0.
- en = 1: count <= next (below); wrap <= overflow flag.
- otherwise: count holds; wrap <= 0.

Step handling:
- s = min(step, LIMIT).
- step == 0 with en = 1 -> count holds, wrap = 0.

Up path:
- sum = count + s, computed in N+1 bits; no truncation before compare.
- sum <= LIMIT -> next = sum, no overflow.
- sum > LIMIT, SATURATE = 0 -> next = sum - (LIMIT+1), overflow = 1.
- sum > LIMIT, SATURATE = 1 -> next = LIMIT, overflow = 1.
- Saturating while already at LIMIT with s > 0 still pulses wrap.

Down path:
- s <= count -> next = count - s.
- s > count, SATURATE = 0 -> next = count + (LIMIT+1) - s, computed in N+1 bits, overflow = 1.
- s > count, SATURATE = 1 -> next = 0, overflow = 1.

Timing and range:
- Latency: count reflects an operation one clock after the sampling edge.
- wrap is high for exactly the cycle following the offending edge.
- Back-to-back overflows give consecutive wrap-high cycles.
- count never leaves 0..LIMIT under any input sequence.
- The whole state is count plus the wrap register. No other state; no X propagation from unused encodings.

Reset and simultaneous events:
- Reset asserted mid-count overrides every input.
- clr, load and en all high in one cycle -> clear only.
- din is ignored unless load = 1.
- up and step are ignored unless en = 1 and no clr/load.

Test Plan:
1. Defaults (N=4, LIMIT=15, SATURATE=0), reset then en=1, up=1, step=1 for 16 cycles -> count 1,2,...,15,0. wrap high only in the cycle count shows 0. at_max high at 15.
2. N=4, LIMIT=9, SATURATE=0: load din=7, then en, up, step=4 -> count 7 -> 1 with wrap=1. Then down, step=3 -> 8 with wrap=1. Then down, step=8 -> 0 with wrap=0 and at_zero=1.
3. N=4, LIMIT=9, SATURATE=1: load 8, up step=5 -> 9 with wrap=1. Repeat -> stays 9, wrap=1 again. Then down step=15 (clamped to 9) -> 0. Then down step=1 -> 0 with wrap=1.
4. Priority: count=5, assert clr=1, load=1, din=12, en=1 together -> count=0. Next cycle load=1, en=1, din=12 -> count=12, wrap=0. Load din=15 with LIMIT=9 -> count=9.
5. Async reset: while counting at 6 with en=1, pull rst_n low between clock edges -> count=0 and wrap=0 before the next edge. Hold rst_n low across 3 edges -> count stays 0. After release, the first edge counts to 1.
6. en=1 with step=0, and en=0 with step=3 -> count holds and wrap=0 in both cases.
